jtag_tap_controller: RTL and testbench
======================================

Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller that drives the team's 4-bit scannable chain (ScannableChain_4_bit) from a standard TCK/TMS/TDI/TDO port. It contains:
- the 16-state TAP FSM
- an instruction register
- a bypass register
- TDO multiplexing

It generates the chain's shift-select (TST) and routes TDI into the chain. It captures the chain's serial output. It sits directly upstream of the scan chain.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
OP_BYPASS, {IR_WIDTH{1'b1}}, selects 1-bit bypass register
OP_SCAN, 'h2, selects external scan chain as data register
OP_IDCODE, 'h1, selects ID register (only with JTAG_IDCODE_EN)
IDCODE_VALUE, 32'h0000_0001, ID register contents (bit0 must be 1)

Ports:
i_TCK  in  1  test clock; all state on posedge
i_RESET  in  1  asynchronous, active-high reset
i_TMS  in  1  test mode select
i_TDI  in  1  serial test data in
i_chain_TDO  in  1  serial out of scan chain (chain o_TDO)
o_chain_TDI  out  1  serial into scan chain (chain i_TDI)
o_TST  out  1  shift-select to scan chain (chain i_TST)
o_TDO  out  1  serial test data out
o_TDO_en  out  1  high while in Shift-IR or Shift-DR
o_state  out  4  current TAP state (encoding below)
o_IR  out  IR_WIDTH  active (updated) instruction
o_update_DR  out  1  one-cycle strobe in Update-DR

Behaviour:
- Clock and reset: one clock, i_TCK. i_RESET is asynchronous and active-high. Reset has priority over everything.
- Reset values: state=TLR(4'hF); IR shift reg=0; o_IR=OP_BYPASS (OP_IDCODE if JTAG_IDCODE_EN); bypass reg=0; o_TST=0; o_TDO=0; o_TDO_en=0; o_update_DR=0.
- State encoding (registered, posedge, next state on i_TMS; TMS value in parentheses):
  - TLR F: 1→TLR, 0→RTI
  - RTI C: 1→SelDR, 0→RTI
  - SelDR 7: 1→SelIR, 0→CapDR
  - CapDR 6: 1→Ex1DR, 0→ShDR
  - ShDR 2: 1→Ex1DR, 0→ShDR
  - Ex1DR 1: 1→UpdDR, 0→PauDR
  - PauDR 3: 1→Ex2DR, 0→PauDR
  - Ex2DR 0: 1→UpdDR, 0→ShDR
  - UpdDR 5: 1→SelDR, 0→RTI
  - SelIR 4: 1→TLR, 0→CapIR
  - CapIR E: 1→Ex1IR, 0→ShIR
  - ShIR A: 1→Ex1IR, 0→ShIR
  - Ex1IR 9: 1→UpdIR, 0→PauIR
  - PauIR B: 1→Ex2IR, 0→PauIR
  - Ex2IR 8: 1→UpdIR, 0→ShIR
  - UpdIR D: 1→SelDR, 0→RTI
- Five consecutive TMS=1 clocks reach TLR from any state.
- Entering TLR (clock edge with next state TLR) reloads o_IR to the reset instruction.
- IR shift register:
  - CapIR edge loads {0..0,2'b01}.
  - ShIR edge shifts right, i_TDI into MSB.
  - UpdIR edge copies the shift register to o_IR.
- Instruction decode: any o_IR value other than OP_SCAN/OP_IDCODE(enabled) selects bypass.
- Bypass: CapDR edge loads 0; ShDR edge loads i_TDI; 1-clock TDI→TDO delay.
- Scan chain:
  - o_chain_TDI = i_TDI (combinational).
  - o_TST = 1 when state==ShDR and o_IR==OP_SCAN, else 0 (combinational from state/IR). In all other states the chain parallel-loads every clock.
- o_TDO (combinational), valid before the next posedge:
  - ShIR: IR shift LSB
  - ShDR: selected DR (bypass bit, i_chain_TDO, or ID LSB)
  - otherwise 0
- o_TDO_en = (state==ShIR || state==ShDR).
- o_update_DR = (state==UpdDR), combinational.
- Reset mid-operation: any partially shifted IR is discarded and o_IR returns to reset instruction; the chain contents are not touched by this block.

Optional Feature:
JTAG_IDCODE_EN:
- Defined: 32-bit ID register. CapDR loads IDCODE_VALUE when o_IR==OP_IDCODE; ShDR shifts right with i_TDI into bit31; o_TDO=bit0. Reset/TLR instruction = OP_IDCODE.
- Undefined: no ID register. OP_IDCODE decodes as bypass; reset/TLR instruction = OP_BYPASS.

Test Plan:
- Assert i_RESET mid-clock (async) → o_state=4'hF, o_IR=4'hF (4'h1 with IDCODE), o_TST=0 immediately, without waiting for a TCK edge.
- From ShDR, drive TMS=1 for 5 clocks → o_state=F; TMS=0 one clock → o_state=C.
- IR scan: TMS 0,1,1,0,0 to reach ShIR, shift 4'h2 LSB-first, Ex1IR, UpdIR. Checks:
  - o_TDO during shift = 1,0,0,0 (captured 01)
  - o_IR=4'h2 after UpdIR
- With OP_SCAN active: CapDR, then 4 ShDR clocks with TDI=1,0,1,1 → o_TST=1 only in ShDR; chain o_out=4'b1101; o_TDO=i_chain_TDO each shift cycle.
- Bypass with o_IR=4'hF: shift TDI=1,0,1,1,0 in ShDR → o_TDO=0 (captured),1,0,1,1; o_TST=0 throughout.
- IDCODE (macro on): after reset, CapDR then 32 ShDR clocks → o_TDO sequence equals IDCODE_VALUE LSB-first, first bit 1.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller driving a 4-bit scannable chain.
// Optional build macro JTAG_IDCODE_EN adds a 32-bit ID register selected by OP_IDCODE.
module jtag_tap_controller #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [IR_WIDTH-1:0] OP_BYPASS    = {IR_WIDTH{1'b1}},
    parameter logic [IR_WIDTH-1:0] OP_SCAN      = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(1),
    parameter logic [31:0]         IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                i_TCK,
    input  logic                i_RESET,
    input  logic                i_TMS,
    input  logic                i_TDI,
    input  logic                i_chain_TDO,
    output logic                o_chain_TDI,
    output logic                o_TST,
    output logic                o_TDO,
    output logic                o_TDO_en,
    output logic [3:0]          o_state,
    output logic [IR_WIDTH-1:0] o_IR,
    output logic                o_update_DR
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RST_IR = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RST_IR = OP_BYPASS;
`endif

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                byp_q, byp_d;
    logic                dr_tdo;

    always_ff @(posedge i_TCK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= TLR;
            ir_sh_q <= '0;
            ir_q    <= RST_IR;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_sh_q <= ir_sh_d;
            ir_q    <= ir_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = i_TMS ? TLR    : RTI;
            RTI:     state_d = i_TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = i_TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = i_TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = i_TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = i_TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = i_TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = i_TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = i_TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = i_TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = i_TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = i_TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = i_TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = i_TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = i_TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = i_TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Capture pattern 01 lets a host confirm IR length and chain integrity.
    always_comb begin
        ir_sh_d = ir_sh_q;
        ir_d    = ir_q;
        byp_d   = byp_q;
        if (state_q == CAP_IR) ir_sh_d = {{(IR_WIDTH-2){1'b0}}, 2'b01};
        if (state_q == SH_IR)  ir_sh_d = {i_TDI, ir_sh_q[IR_WIDTH-1:1]};
        if (state_d == TLR)
            ir_d = RST_IR;
        else if (state_q == UPD_IR)
            ir_d = ir_sh_q;
        if (state_q == CAP_DR) byp_d = 1'b0;
        if (state_q == SH_DR)  byp_d = i_TDI;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_q, id_d;

    always_ff @(posedge i_TCK or posedge i_RESET) begin
        if (i_RESET) id_q <= '0;
        else         id_q <= id_d;
    end

    always_comb begin
        id_d = id_q;
        if (ir_q == OP_IDCODE) begin
            if (state_q == CAP_DR) id_d = IDCODE_VALUE;
            if (state_q == SH_DR)  id_d = {i_TDI, id_q[31:1]};
        end
    end

    always_comb begin
        if (ir_q == OP_SCAN)        dr_tdo = i_chain_TDO;
        else if (ir_q == OP_IDCODE) dr_tdo = id_q[0];
        else                        dr_tdo = byp_q;
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^{IDCODE_VALUE, OP_IDCODE};

    always_comb begin
        if (ir_q == OP_SCAN) dr_tdo = i_chain_TDO;
        else                 dr_tdo = byp_q;
    end
`endif

    always_comb begin
        o_TDO = 1'b0;
        if (state_q == SH_IR) o_TDO = ir_sh_q[0];
        if (state_q == SH_DR) o_TDO = dr_tdo;
    end

    assign o_chain_TDI = i_TDI;
    assign o_TST       = (state_q == SH_DR) && (ir_q == OP_SCAN);
    assign o_TDO_en    = (state_q == SH_IR) || (state_q == SH_DR);
    assign o_update_DR = (state_q == UPD_DR);
    assign o_state     = state_q;
    assign o_IR        = ir_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Scoreboard bench for jtag_tap_controller: table-driven TAP reference model,
// randomized TMS/TDI walks, directed IR/DR scans and mid-cycle async resets.
module tb_jtag_tap_controller;

    localparam int IRW = 4;
    localparam int OP_SCAN_I = 2;
    localparam int OP_ID_I = 1;
    localparam logic [31:0] IDV = 32'h0000_0001;
`ifdef JTAG_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic i_TCK, i_RESET, i_TMS, i_TDI, i_chain_TDO;
    logic o_chain_TDI, o_TST, o_TDO, o_TDO_en, o_update_DR;
    logic [3:0] o_state;
    logic [IRW-1:0] o_IR;

    jtag_tap_controller dut (
        .i_TCK(i_TCK), .i_RESET(i_RESET), .i_TMS(i_TMS), .i_TDI(i_TDI),
        .i_chain_TDO(i_chain_TDO), .o_chain_TDI(o_chain_TDI), .o_TST(o_TST),
        .o_TDO(o_TDO), .o_TDO_en(o_TDO_en), .o_state(o_state), .o_IR(o_IR),
        .o_update_DR(o_update_DR)
    );

    initial i_TCK = 1'b0;
    always #5 i_TCK = ~i_TCK;

    // Behavioural stand-in for the 4-bit scannable chain.
    logic [3:0] chain_q = 4'h0;
    always @(posedge i_TCK) begin
        if (o_TST) chain_q <= {o_chain_TDI, chain_q[3:1]};
        else       chain_q <= 4'($urandom);
    end
    assign i_chain_TDO = chain_q[0];

    typedef struct {
        int st; int ir; int tst; int tdo; int en; int upd; int ctdi;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;

    // Next-state tables indexed by state code, for TMS=0 and TMS=1.
    int nx0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int m_state, m_irsh, m_ir, m_byp;
    longint m_id;

    function automatic int rst_ir();
        return ID_EN ? OP_ID_I : (1 << IRW) - 1;
    endfunction

    task automatic model_reset();
        m_state = 15; m_irsh = 0; m_ir = rst_ir(); m_byp = 0; m_id = 0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit tms, input bit tdi);
        exp_t e;
        int dr, nxt;
        @(negedge i_TCK);
        i_TMS = tms;
        i_TDI = tdi;
        if (m_ir == OP_SCAN_I)           dr = int'(chain_q[0]);
        else if (ID_EN && m_ir == OP_ID_I) dr = int'(m_id % 2);
        else                             dr = m_byp;
        e.st   = m_state;
        e.ir   = m_ir;
        e.tst  = (m_state == 2 && m_ir == OP_SCAN_I) ? 1 : 0;
        e.tdo  = (m_state == 10) ? m_irsh % 2 : (m_state == 2) ? dr : 0;
        e.en   = (m_state == 2 || m_state == 10) ? 1 : 0;
        e.upd  = (m_state == 5) ? 1 : 0;
        e.ctdi = tdi;
        expq.push_back(e);
        nxt = tms ? nx1[m_state] : nx0[m_state];
        if (nxt == 15)        m_ir = rst_ir();
        else if (m_state == 13) m_ir = m_irsh;
        if (m_state == 14) m_irsh = 1;
        if (m_state == 10) m_irsh = (m_irsh / 2) + tdi * (1 << (IRW - 1));
        if (m_state == 6) begin
            m_byp = 0;
            if (ID_EN && m_ir == OP_ID_I) m_id = longint'(IDV);
        end
        if (m_state == 2) begin
            m_byp = tdi;
            if (ID_EN && m_ir == OP_ID_I) m_id = (m_id / 2) + longint'(tdi) * 64'h8000_0000;
        end
        m_state = nxt;
    endtask

    // Monitor: every TCK cycle the DUT presents a full set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_TCK);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("state", int'(o_state), e.st);
                chk("ir", int'(o_IR), e.ir);
                chk("tst", int'(o_TST), e.tst);
                chk("tdo", int'(o_TDO), e.tdo);
                chk("tdo_en", int'(o_TDO_en), e.en);
                chk("update_dr", int'(o_update_DR), e.upd);
                chk("chain_tdi", int'(o_chain_TDI), e.ctdi);
            end
        end
    end

    task automatic reset_checks();
        chk("rst_state", int'(o_state), 15);
        chk("rst_ir", int'(o_IR), rst_ir());
        chk("rst_tst", int'(o_TST), 0);
        chk("rst_tdo", int'(o_TDO), 0);
        chk("rst_tdo_en", int'(o_TDO_en), 0);
        chk("rst_update_dr", int'(o_update_DR), 0);
    endtask

    // Assert reset between edges and check outputs before any TCK edge.
    task automatic mid_reset();
        @(posedge i_TCK);
        #2 i_RESET = 1'b1;
        #1 reset_checks();
        model_reset();
        #1 i_RESET = 1'b0;
    endtask

    task automatic ir_scan_from_rti(input logic [IRW-1:0] val);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IRW; i++) step(i == IRW - 1, val[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_enter_shift();
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    initial begin
        logic [3:0] scan_bits;
        logic [4:0] byp_bits;
        int budget;
        i_RESET = 1'b1;
        i_TMS = 1'b1;
        i_TDI = 1'b0;
        model_reset();
        #11 reset_checks();
        #1 i_RESET = 1'b0;

        // IR scan of OP_SCAN from TLR: TMS 0 then 1,1,0,0 to Shift-IR.
        step(0, 0);
        ir_scan_from_rti(4'h2);

        // Scan chain DR shift of 1,0,1,1.
        scan_bits = 4'b1101;
        dr_enter_shift();
        for (int i = 0; i < 4; i++) step(i == 3, scan_bits[i]);
        @(posedge i_TCK);
        #1 chk("chain_contents", int'(chain_q), 4'b1101);
        step(1, 0); step(0, 0);

        // Five TMS=1 from Shift-DR lands in TLR, then one TMS=0 to RTI.
        dr_enter_shift();
        step(0, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(0, 0);
        step(0, 0);

        // Bypass path: load all-ones IR and shift 1,0,1,1,0.
        ir_scan_from_rti(4'hF);
        byp_bits = 5'b01101;
        dr_enter_shift();
        for (int i = 0; i < 5; i++) step(i == 4, byp_bits[i]);
        step(1, 0); step(0, 0);

        // Reset-time instruction then 32-bit DR shift (ID register when enabled).
        mid_reset();
        step(0, 0);
        dr_enter_shift();
        for (int i = 0; i < 32; i++) step(i == 31, 1'($urandom));
        step(1, 0); step(0, 0);

        // Random walks with occasional async reset in the middle of a cycle.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 150; i++)
                step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 1'($urandom));
            mid_reset();
        end
        for (int i = 0; i < 300; i++) step(1'($urandom), 1'($urandom));

        budget = 0;
        while (expq.size() > 0 && budget < 20) begin
            @(posedge i_TCK);
            budget++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
